// File: rtl/pipeline_pkg.sv
// Shared constants for the pipeline: ALU op codes, WB control bit
// positions and the execute-stage FSM state encodings.
package pipeline_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADDU  = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_SUBU  = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOR   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_SLL   = 4'd10;
  localparam logic [3:0] OP_SRL   = 4'd11;
  localparam logic [3:0] OP_SRA   = 4'd12;
  localparam logic [3:0] OP_MULTU = 4'd13;
  localparam logic [3:0] OP_MFHI  = 4'd14;
  localparam logic [3:0] OP_MFLO  = 4'd15;

  // Bit positions inside the 2-bit WB control bundle.
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // Execute-stage FSM: IDLE accepts instructions, MUL runs the multiplier.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/multu_iter.sv
// Iterative unsigned shift-add multiplier. The multiplier operand sits in
// the low half of the accumulator and is shifted out one bit per cycle
// while the partial product grows into the upper half.
module multu_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int CW = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic               busy_r;
  logic [WIDTH:0]     partial;

  // Add the multiplicand into the upper half when the current multiplier bit is set.
  always_comb begin
    partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  end

  // product is the accumulator after this cycle's iteration, so on the
  // final iteration it already holds the complete result.
  assign product = {partial, acc[WIDTH-1:1]};
  assign done    = busy_r && (count == LAST);
  assign busy    = busy_r;

  // Load operands on start, then run one iteration per cycle until the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      count  <= '0;
      busy_r <= 1'b0;
    end else if (start && !busy_r) begin
      mcand  <= multiplicand;
      acc    <= {{WIDTH{1'b0}}, multiplier};
      count  <= '0;
      busy_r <= 1'b1;
    end else if (busy_r) begin
      acc   <= product;
      count <= count + CW'(1);
      if (count == LAST) begin
        busy_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, destination selection, HI/LO multiply unit and the
// EX/MEM pipeline register feeding the memory stage.
module ex_stage
  import pipeline_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic             flush,
  input  logic [1:0]       control_wb_in,
  input  logic             MemRead_in,
  input  logic             MemWrite_in,
  input  logic [3:0]       alu_op,
  input  logic             alu_src,
  input  logic             reg_dst,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [WIDTH-1:0] imm,
  input  logic [4:0]       shamt,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  output logic             busy,
  output logic [1:0]       control_wb,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [WIDTH-1:0] address,
  output logic [WIDTH-1:0] writeData,
  output logic [4:0]       write_register,
  output logic             out_valid,
  output logic             overflow
);

  logic [0:0]         state;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   add_res;
  logic [WIDTH-1:0]   sub_res;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_ovf;
  logic               accept;
  logic               is_multu;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [1:0]         wb_next;

  assign op_b     = alu_src ? imm : rt_data;
  assign add_res  = rs_data + op_b;
  assign sub_res  = rs_data - op_b;
  assign is_multu = (alu_op == OP_MULTU);
  assign accept   = in_valid && !flush && (state == ST_IDLE) && !mul_busy;
  assign busy     = (state == ST_MUL);

  multu_iter #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_multu (
    .clk          (CLK),
    .rst          (RST),
    .start        (accept && is_multu),
    .multiplicand (rs_data),
    .multiplier   (op_b),
    .busy         (mul_busy),
    .product      (mul_product),
    .done         (mul_done)
  );

  // ALU result and signed-overflow detection for ADD/SUB.
  always_comb begin
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_result = add_res;
        alu_ovf    = (rs_data[WIDTH-1] == op_b[WIDTH-1]) && (add_res[WIDTH-1] != rs_data[WIDTH-1]);
      end
      OP_ADDU: alu_result = add_res;
      OP_SUB: begin
        alu_result = sub_res;
        alu_ovf    = (rs_data[WIDTH-1] != op_b[WIDTH-1]) && (sub_res[WIDTH-1] != rs_data[WIDTH-1]);
      end
      OP_SUBU:  alu_result = sub_res;
      OP_AND:   alu_result = rs_data & op_b;
      OP_OR:    alu_result = rs_data | op_b;
      OP_XOR:   alu_result = rs_data ^ op_b;
      OP_NOR:   alu_result = ~(rs_data | op_b);
      OP_SLT:   alu_result = {{(WIDTH-1){1'b0}}, ($signed(rs_data) < $signed(op_b))};
      OP_SLTU:  alu_result = {{(WIDTH-1){1'b0}}, (rs_data < op_b)};
      OP_SLL:   alu_result = op_b << shamt;
      OP_SRL:   alu_result = op_b >> shamt;
      OP_SRA:   alu_result = $unsigned($signed(op_b) >>> shamt);
      OP_MFHI:  alu_result = hi;
      OP_MFLO:  alu_result = lo;
      default:  alu_result = '0;
    endcase
  end

  // An overflowing ADD/SUB still travels down the pipe but must not write a register.
  always_comb begin
    wb_next              = '0;
    wb_next[WB_REGWRITE] = control_wb_in[WB_REGWRITE] && !alu_ovf;
    wb_next[WB_MEMTOREG] = control_wb_in[WB_MEMTOREG];
  end

  // FSM and HI/LO: start the multiply on an accepted MULTU, capture the product when it finishes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && is_multu) begin
            state <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            hi    <= mul_product[2*WIDTH-1:WIDTH];
            lo    <= mul_product[WIDTH-1:0];
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // EX/MEM register: load accepted non-MULTU instructions, otherwise insert a bubble with held data fields.
  always_ff @(posedge CLK) begin
    if (RST) begin
      control_wb     <= '0;
      MemRead        <= 1'b0;
      MemWrite       <= 1'b0;
      address        <= '0;
      writeData      <= '0;
      write_register <= '0;
      out_valid      <= 1'b0;
      overflow       <= 1'b0;
    end else if (accept && !is_multu) begin
      control_wb     <= wb_next;
      MemRead        <= MemRead_in;
      MemWrite       <= MemWrite_in;
      address        <= alu_result;
      writeData      <= rt_data;
      write_register <= reg_dst ? rd : rt;
      out_valid      <= 1'b1;
      overflow       <= alu_ovf;
    end else begin
      control_wb <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, multi-cycle
// multiply/reset/flush sequences, and randomized traffic against a
// plain-arithmetic reference model.
module tb_ex_stage;

  typedef struct {
    logic [3:0]  op;
    logic        src;
    logic        dst;
    logic [31:0] rs;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [4:0]  sh;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [1:0]  cwb;
    logic        mr;
    logic        mw;
  } stim_t;

  typedef struct {
    string       name;
    stim_t       s;
    logic [31:0] exp_addr;
    logic [4:0]  exp_wr;
    logic [1:0]  exp_cwb;
    logic        exp_ovf;
  } vec_t;

  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  logic        CLK = 1'b0;
  logic        RST, in_valid, flush, MemRead_in, MemWrite_in, alu_src, reg_dst;
  logic [1:0]  control_wb_in;
  logic [3:0]  alu_op;
  logic [31:0] rs_data, rt_data, imm;
  logic [4:0]  shamt, rt, rd;
  logic        busy, MemRead, MemWrite, out_valid, overflow;
  logic [1:0]  control_wb;
  logic [31:0] address, writeData;
  logic [4:0]  write_register;

  int checks = 0;
  int passes = 0;

  vec_t vecs[12];

  always #5 CLK = ~CLK;

  ex_stage dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .flush(flush),
    .control_wb_in(control_wb_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .shamt(shamt), .rt(rt), .rd(rd),
    .busy(busy), .control_wb(control_wb), .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .writeData(writeData), .write_register(write_register),
    .out_valid(out_valid), .overflow(overflow)
  );

  function automatic stim_t mkStim(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    stim_t s;
    s.op = op; s.src = 1'b0; s.dst = 1'b1; s.rs = a; s.rtd = b; s.imm = '0;
    s.sh = '0; s.rt = 5'd2; s.rd = 5'd3; s.cwb = 2'b10; s.mr = 1'b0; s.mw = 1'b0;
    return s;
  endfunction

  // Reference ALU: defined from the instruction semantics with wide signed arithmetic.
  function automatic void refAlu(input stim_t s, input logic [31:0] h, input logic [31:0] l,
                                 output logic [31:0] res, output logic ovf);
    logic [31:0] b;
    longint sa, sb, t;
    b   = s.src ? s.imm : s.rtd;
    sa  = longint'($signed(s.rs));
    sb  = longint'($signed(b));
    res = '0;
    ovf = 1'b0;
    t   = 0;
    case (s.op)
      4'd0: begin t = sa + sb; res = t[31:0]; ovf = (t > MAXI) || (t < MINI); end
      4'd1: res = s.rs + b;
      4'd2: begin t = sa - sb; res = t[31:0]; ovf = (t > MAXI) || (t < MINI); end
      4'd3: res = s.rs - b;
      4'd4: res = s.rs & b;
      4'd5: res = s.rs | b;
      4'd6: res = s.rs ^ b;
      4'd7: res = ~(s.rs | b);
      4'd8: res = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: res = (s.rs < b) ? 32'd1 : 32'd0;
      4'd10: res = b << s.sh;
      4'd11: res = b >> s.sh;
      4'd12: begin t = sb >>> s.sh; res = t[31:0]; end
      4'd14: res = h;
      4'd15: res = l;
      default: res = '0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic checkEx(input string tag, input logic [31:0] ea, input logic [31:0] ewd,
                         input logic [4:0] ewr, input logic [1:0] ecwb, input logic emr,
                         input logic emw, input logic ev, input logic eov);
    checkOutput({tag, ".address"}, address, ea);
    checkOutput({tag, ".writeData"}, writeData, ewd);
    checkOutput({tag, ".write_register"}, 32'(write_register), 32'(ewr));
    checkOutput({tag, ".control_wb"}, 32'(control_wb), 32'(ecwb));
    checkOutput({tag, ".MemRead"}, 32'(MemRead), 32'(emr));
    checkOutput({tag, ".MemWrite"}, 32'(MemWrite), 32'(emw));
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(eov));
  endtask

  task automatic setInputs(input stim_t s, input logic v, input logic f);
    alu_op = s.op; alu_src = s.src; reg_dst = s.dst; rs_data = s.rs; rt_data = s.rtd;
    imm = s.imm; shamt = s.sh; rt = s.rt; rd = s.rd; control_wb_in = s.cwb;
    MemRead_in = s.mr; MemWrite_in = s.mw; in_valid = v; flush = f;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input stim_t s, input logic v, input logic f);
    setInputs(s, v, f);
    tick();
  endtask

  task automatic idleInputs();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Count cycles with busy high, with a bound so a stuck multiplier still ends the run.
  task automatic waitIdle(input string tag, output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      checkOutput({tag, ".bubble_valid"}, 32'(out_valid), 32'd0);
      n++;
      tick();
    end
    if (n >= 100) checkOutput({tag, ".busy_timeout"}, 32'(busy), 32'd0);
  endtask

  initial begin
    stim_t s;
    logic [31:0] res, mhi, mlo, pa, pwd;
    logic [4:0] pwr;
    logic ov, v, f;
    logic [63:0] prod;
    int n;

    // Directed vector table.
    s = mkStim(4'd0, 32'd0, 32'd7); s.src = 1; s.imm = 32'd10; s.dst = 0; s.rt = 5'd24; s.mw = 1; s.cwb = 2'b00;
    vecs[0] = '{"store", s, 32'd10, 5'd24, 2'b00, 1'b0};
    s = mkStim(4'd0, 32'h7FFFFFFF, 32'd1); s.rd = 5'd5;
    vecs[1] = '{"add_ovf", s, 32'h80000000, 5'd5, 2'b00, 1'b1};
    s = mkStim(4'd1, 32'h7FFFFFFF, 32'd1); s.rd = 5'd5;
    vecs[2] = '{"addu_noovf", s, 32'h80000000, 5'd5, 2'b10, 1'b0};
    s = mkStim(4'd2, 32'd20, 32'd3);
    vecs[3] = '{"sub", s, 32'd17, 5'd3, 2'b10, 1'b0};
    s = mkStim(4'd2, 32'h80000000, 32'd1); s.cwb = 2'b11; s.mr = 1;
    vecs[4] = '{"sub_ovf", s, 32'h7FFFFFFF, 5'd3, 2'b01, 1'b1};
    s = mkStim(4'd8, 32'hFFFFFFFF, 32'd1);
    vecs[5] = '{"slt", s, 32'd1, 5'd3, 2'b10, 1'b0};
    s = mkStim(4'd9, 32'hFFFFFFFF, 32'd1);
    vecs[6] = '{"sltu", s, 32'd0, 5'd3, 2'b10, 1'b0};
    s = mkStim(4'd12, 32'd0, 32'h80000000); s.sh = 5'd4;
    vecs[7] = '{"sra", s, 32'hF8000000, 5'd3, 2'b10, 1'b0};
    s = mkStim(4'd10, 32'd0, 32'd1); s.sh = 5'd31; s.dst = 0; s.rt = 5'd17;
    vecs[8] = '{"sll", s, 32'h80000000, 5'd17, 2'b10, 1'b0};
    s = mkStim(4'd11, 32'd0, 32'h80000000); s.sh = 5'd31;
    vecs[9] = '{"srl", s, 32'd1, 5'd3, 2'b10, 1'b0};
    s = mkStim(4'd7, 32'hF0F0F0F0, 32'h0FF00FF0);
    vecs[10] = '{"nor", s, 32'h000F000F, 5'd3, 2'b10, 1'b0};
    s = mkStim(4'd3, 32'd0, 32'd1);
    vecs[11] = '{"subu_wrap", s, 32'hFFFFFFFF, 5'd3, 2'b10, 1'b0};

    // Reset state.
    RST = 1'b1;
    setInputs(mkStim(4'd0, 32'd0, 32'd0), 1'b0, 1'b0);
    tick(); tick();
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkEx("reset", 32'd0, 32'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].s, 1'b1, 1'b0);
      checkEx(vecs[i].name, vecs[i].exp_addr, vecs[i].s.rtd, vecs[i].exp_wr, vecs[i].exp_cwb,
              vecs[i].s.mr, vecs[i].s.mw, 1'b1, vecs[i].exp_ovf);
    end

    // Bubble holds data fields.
    idleInputs(); tick();
    checkEx("bubble", 32'hFFFFFFFF, 32'd1, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // MULTU 0xFFFFFFFF x 2 with MFHI held upstream until busy drops.
    applyStimulus(mkStim(4'd13, 32'hFFFFFFFF, 32'd2), 1'b1, 1'b0);
    checkOutput("multu.busy_start", 32'(busy), 32'd1);
    s = mkStim(4'd14, 32'd0, 32'd0); s.rd = 5'd9;
    setInputs(s, 1'b1, 1'b0);
    waitIdle("multu", n);
    checkOutput("multu.busy_cycles", 32'(n), 32'd32);
    tick();
    checkEx("mfhi", 32'd1, 32'd0, 5'd9, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(mkStim(4'd15, 32'd0, 32'd0), 1'b1, 1'b0);
    checkOutput("mflo.address", address, 32'hFFFFFFFE);

    // Reset in the middle of a multiply.
    applyStimulus(mkStim(4'd13, 32'd5, 32'd7), 1'b1, 1'b0);
    idleInputs();
    repeat (10) tick();
    checkOutput("abort.busy_mid", 32'(busy), 32'd1);
    RST = 1'b1; tick(); RST = 1'b0;
    checkOutput("abort.busy", 32'(busy), 32'd0);
    checkEx("abort", 32'd0, 32'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(mkStim(4'd15, 32'd0, 32'd0), 1'b1, 1'b0);
    checkOutput("abort.mflo", address, 32'd0);
    checkOutput("abort.mflo_valid", 32'(out_valid), 32'd1);
    applyStimulus(mkStim(4'd14, 32'd0, 32'd0), 1'b1, 1'b0);
    checkOutput("abort.mfhi", address, 32'd0);

    // Flush cancels only this cycle's instruction.
    applyStimulus(mkStim(4'd2, 32'd20, 32'd3), 1'b1, 1'b1);
    checkOutput("flush.valid", 32'(out_valid), 32'd0);
    checkOutput("flush.cwb", 32'(control_wb), 32'd0);
    applyStimulus(mkStim(4'd2, 32'd20, 32'd3), 1'b1, 1'b0);
    checkOutput("unflush.address", address, 32'd17);
    checkOutput("unflush.valid", 32'(out_valid), 32'd1);
    applyStimulus(mkStim(4'd13, 32'd3, 32'd4), 1'b1, 1'b1);
    checkOutput("flush_multu.busy", 32'(busy), 32'd0);

    // Flush during MUL does not disturb the multiply.
    applyStimulus(mkStim(4'd13, 32'd3, 32'd4), 1'b1, 1'b0);
    setInputs(mkStim(4'd0, 32'd1, 32'd1), 1'b1, 1'b1);
    repeat (5) tick();
    idleInputs();
    waitIdle("flush_mul", n);
    checkOutput("flush_mul.busy_cycles", 32'(n + 5), 32'd32);
    applyStimulus(mkStim(4'd15, 32'd0, 32'd0), 1'b1, 1'b0);
    checkOutput("flush_mul.mflo", address, 32'd12);

    // Reset wins over flush.
    RST = 1'b1;
    applyStimulus(mkStim(4'd0, 32'd1, 32'd1), 1'b1, 1'b1);
    RST = 1'b0;
    checkEx("rst_flush", 32'd0, 32'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random multiplies against a 64-bit product.
    mhi = '0; mlo = '0;
    for (int k = 0; k < 3; k++) begin
      s = mkStim(4'd13, $urandom, $urandom);
      prod = 64'(s.rs) * 64'(s.rtd);
      applyStimulus(s, 1'b1, 1'b0);
      idleInputs();
      waitIdle("rmul", n);
      checkOutput("rmul.busy_cycles", 32'(n), 32'd32);
      applyStimulus(mkStim(4'd14, 32'd0, 32'd0), 1'b1, 1'b0);
      checkOutput("rmul.hi", address, prod[63:32]);
      applyStimulus(mkStim(4'd15, 32'd0, 32'd0), 1'b1, 1'b0);
      checkOutput("rmul.lo", address, prod[31:0]);
      mhi = prod[63:32]; mlo = prod[31:0];
    end

    // Random single-cycle traffic with random valid/flush.
    pa = address; pwd = writeData; pwr = write_register;
    for (int i = 0; i < 150; i++) begin
      s.op  = 4'($urandom_range(0, 15));
      if (s.op == 4'd13) s.op = 4'd14;
      s.src = 1'($urandom); s.dst = 1'($urandom);
      s.rs  = $urandom; s.rtd = $urandom; s.imm = $urandom;
      if (i % 4 == 0) begin s.rs = 32'h7FFFFFFF - 32'($urandom_range(0, 3)); s.imm = 32'($urandom_range(0, 4)); end
      s.sh  = 5'($urandom); s.rt = 5'($urandom); s.rd = 5'($urandom);
      s.cwb = 2'($urandom); s.mr = 1'($urandom); s.mw = 1'($urandom);
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 7) == 0);
      applyStimulus(s, v, f);
      if (v && !f) begin
        refAlu(s, mhi, mlo, res, ov);
        pa = res; pwd = s.rtd; pwr = s.dst ? s.rd : s.rt;
        checkEx("rand", pa, pwd, pwr, ov ? {1'b0, s.cwb[0]} : s.cwb, s.mr, s.mw, 1'b1, ov);
      end else begin
        checkEx("rand_bubble", pa, pwd, pwr, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
